// File: rtl/cdc_pkg.sv
// cdc_pkg -- shared definitions for the toggle-based CDC event transmitter.
//   state_t          : transmitter FSM states (IDLE, HOLD)
//   MIN_HOLD_CYCLES  : smallest legal spacing between toggle changes
package cdc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int MIN_HOLD_CYCLES = 2;

endpackage : cdc_pkg

// File: rtl/cdc_toggle_tx.sv
// cdc_toggle_tx -- converts accepted events into changes of a registered
// toggle level. Consecutive changes are spaced at least HOLD_CYCLES clk edges
// apart so a downstream synchroniser/pulse stage can see each one. Events
// arriving faster than that are queued in a saturating pending counter.
//
// Parameters
//   HOLD_CYCLES : minimum clk cycles between toggle changes (>= 2)
//   PEND_WIDTH  : width of the pending-event counter
//
// Ports
//   clk      in   single clock; all logic is in this domain
//   aresetn  in   asynchronous, active-low reset
//   ev_valid in   event request
//   ev_ready out  event accepted when ev_valid && ev_ready at a clk edge
//   toggle   out  registered level; every change is one event
//   pending  out  accepted events not yet toggled (saturates, never wraps)
//   busy     out  high while holding off or while events are pending
//   overflow out  sticky dropped-event flag (drop mode only, else 0)
//
// Build option
//   CDC_TOGGLE_TX_DROP_EN : ev_ready is tied high; an event arriving while
//   pending is at its maximum is dropped and sets overflow until reset.
//   Undefined (default): ev_ready backpressures when pending is full.
//
// Integration note: asserting aresetn forces toggle to 0 immediately. If
// toggle was 1, the receiver sees a 1->0 change that is not an event; reset
// both sides together or ignore the receiver output around reset. Pending
// events are discarded by reset.
module cdc_toggle_tx
  import cdc_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int PEND_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  output logic                  toggle,
  output logic [PEND_WIDTH-1:0] pending,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  // The counter covers the edges between two toggle changes: loaded on the
  // toggle edge, it reaches 0 one edge before the next change may happen,
  // which places consecutive changes exactly HOLD_CYCLES edges apart.
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  generate
    if (HOLD_CYCLES < MIN_HOLD_CYCLES) begin : g_bad_hold
      $error("cdc_toggle_tx: HOLD_CYCLES must be >= 2");
    end
  endgenerate

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             pend_full;
  logic             accept;
  logic             fire;

  // Full is judged on the registered count only, so a decrement on the same
  // edge cannot open the door early and ev_valid never reaches ev_ready.
  assign pend_full = (pending == PEND_MAX);
  assign accept    = ev_valid && !pend_full;
  assign fire      = (pending != '0) &&
                     ((state == IDLE) || (hold_cnt == '0));
  assign busy      = (state == HOLD) || (pending != '0);

`ifdef CDC_TOGGLE_TX_DROP_EN
  assign ev_ready = 1'b1;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      overflow <= 1'b0;
    end else if (ev_valid && pend_full) begin
      overflow <= 1'b1;
    end
  end
`else
  assign ev_ready = !pend_full;
  assign overflow = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      hold_cnt <= '0;
      toggle   <= 1'b0;
      pending  <= '0;
    end else begin
      // Accept and toggle on the same edge cancel out.
      case ({accept, fire})
        2'b10:   pending <= pending + PEND_WIDTH'(1);
        2'b01:   pending <= pending - PEND_WIDTH'(1);
        default: pending <= pending;
      endcase

      case (state)
        IDLE: begin
          if (fire) begin
            toggle   <= ~toggle;
            hold_cnt <= HOLD_LOAD;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end else if (fire) begin
            toggle   <= ~toggle;
            hold_cnt <= HOLD_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule : cdc_toggle_tx

// File: tb/tb_cdc_toggle_tx.sv
// tb_cdc_toggle_tx -- directed, self-checking bench for cdc_toggle_tx with
// HOLD_CYCLES=4, PEND_WIDTH=2 (pending max 3). Expected values are traced by
// hand in the comments next to each vector. The drop-mode sequence runs only
// when CDC_TOGGLE_TX_DROP_EN is defined; the backpressure sequence only when
// it is not.
module tb_cdc_toggle_tx;

  logic       clk;
  logic       aresetn;
  logic       ev_valid;
  logic       ev_ready;
  logic       toggle;
  logic [1:0] pending;
  logic       busy;
  logic       overflow;

  int n_cmp  = 0;
  int n_fail = 0;
  int tog_changes;
  logic tog_prev;

  cdc_toggle_tx #(
    .HOLD_CYCLES(4),
    .PEND_WIDTH (2)
  ) dut (
    .clk     (clk),
    .aresetn (aresetn),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .toggle  (toggle),
    .pending (pending),
    .busy    (busy),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One clk edge, then sample 1 time unit later; also counts toggle changes.
  task automatic step();
    @(posedge clk);
    #1;
    if (toggle !== tog_prev) tog_changes++;
    tog_prev = toggle;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    aresetn  = 1'b0;
    ev_valid = 1'b0;
    #1;
    tog_prev    = 1'b0;
    tog_changes = 0;
    steps(2);
    aresetn = 1'b1;
    steps(1);
  endtask

`ifndef CDC_TOGGLE_TX_DROP_EN
  // Backpressure sequence: ev_valid high for 11 edges E0..E10.
  int exp_pend [11] = '{1, 1, 2, 3, 3, 2, 3, 3, 3, 2, 3};
  int exp_ready[11] = '{1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 0};
`endif

  initial begin
    aresetn     = 1'b0;
    ev_valid    = 1'b0;
    tog_prev    = 1'b0;
    tog_changes = 0;
    #2;
    // Reset state, before any clock edge.
    check("rst_toggle",   toggle,   0);
    check("rst_pending",  pending,  0);
    check("rst_busy",     busy,     0);
    check("rst_overflow", overflow, 0);
    check("rst_ready",    ev_ready, 1);
    steps(2);
    aresetn = 1'b1;
    steps(3);
    check("rst_no_toggle", tog_changes, 0);

    // ---- Single event: accept at E0, toggle at E1, busy falls at E5.
    ev_valid = 1'b1;
    step();                                   // E0
    ev_valid = 1'b0;
    check("single_pend_e0",   pending, 1);
    check("single_tog_e0",    toggle,  0);
    check("single_busy_e0",   busy,    1);
    step();                                   // E1
    check("single_tog_e1",    toggle,  1);
    check("single_pend_e1",   pending, 0);
    steps(3);                                 // E4
    check("single_busy_e4",   busy,    1);
    step();                                   // E5
    check("single_busy_e5",   busy,    0);
    check("single_tog_e5",    toggle,  1);

    // ---- Three events at E0..E2: toggles at E1, E5, E9 (toggle starts 1).
    ev_valid = 1'b1;
    step();                                   // E0
    check("burst_pend_e0",  pending, 1);
    check("burst_ready_e0", ev_ready, 1);
    step();                                   // E1: accept + toggle
    check("burst_pend_e1",  pending, 1);
    check("burst_tog_e1",   toggle,  0);
    check("burst_ready_e1", ev_ready, 1);
    step();                                   // E2
    ev_valid = 1'b0;
    check("burst_pend_e2",  pending, 2);
    check("burst_ready_e2", ev_ready, 1);
    step();                                   // E3
    check("burst_pend_e3",  pending, 2);
    step();                                   // E4: still holding off
    check("burst_tog_e4",   toggle,  0);
    step();                                   // E5
    check("burst_tog_e5",   toggle,  1);
    check("burst_pend_e5",  pending, 1);
    steps(3);                                 // E8
    check("burst_tog_e8",   toggle,  1);
    step();                                   // E9
    check("burst_tog_e9",   toggle,  0);
    check("burst_pend_e9",  pending, 0);
    steps(3);                                 // E12
    check("burst_busy_e12", busy,    1);
    step();                                   // E13
    check("burst_busy_e13", busy,    0);

`ifndef CDC_TOGGLE_TX_DROP_EN
    // ---- Backpressure: ev_valid held high for E0..E10, 6 events accepted.
    tog_changes = 0;
    ev_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      check($sformatf("bp_pend_e%0d", i),  pending,  exp_pend[i]);
      check($sformatf("bp_ready_e%0d", i), ev_ready, exp_ready[i]);
      check($sformatf("bp_ovf_e%0d", i),   overflow, 0);
    end
    ev_valid = 1'b0;
    steps(30);
    check("bp_toggle_count", tog_changes, 6);
    check("bp_drained_pend", pending,     0);
    check("bp_drained_busy", busy,        0);
    check("bp_ovf_end",      overflow,    0);
`else
    // ---- Drop mode: ev_valid high for E0..E4, event at E4 dropped.
    do_reset();
    ev_valid = 1'b1;
    step();
    check("drop_pend_e0",  pending,  1);
    check("drop_ready_e0", ev_ready, 1);
    step();
    check("drop_pend_e1",  pending,  1);
    step();
    check("drop_pend_e2",  pending,  2);
    step();
    check("drop_pend_e3",  pending,  3);
    check("drop_ready_e3", ev_ready, 1);
    check("drop_ovf_e3",   overflow, 0);
    step();
    ev_valid = 1'b0;
    check("drop_pend_e4",  pending,  3);
    check("drop_ovf_e4",   overflow, 1);
    steps(20);
    check("drop_toggle_count", tog_changes, 4);
    check("drop_ovf_sticky",   overflow,    1);
    check("drop_drained_pend", pending,     0);
`endif

    // ---- Reset in HOLD with pending=2, toggle=1.
    do_reset();
    ev_valid = 1'b1;
    steps(3);                                 // E0..E2
    ev_valid = 1'b0;
    check("mid_pre_pend",   pending, 2);
    check("mid_pre_toggle", toggle,  1);
    check("mid_pre_busy",   busy,    1);
    aresetn = 1'b0;
    #1;                                       // before next edge
    check("mid_rst_toggle", toggle,   0);
    check("mid_rst_pend",   pending,  0);
    check("mid_rst_ovf",    overflow, 0);
    check("mid_rst_ready",  ev_ready, 1);
    check("mid_rst_busy",   busy,     0);
    tog_prev    = toggle;
    tog_changes = 0;
    steps(1);
    aresetn = 1'b1;
    steps(10);
    check("mid_post_changes", tog_changes, 0);
    check("mid_post_toggle",  toggle,      0);
    check("mid_post_busy",    busy,        0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_cdc_toggle_tx
